// File: rtl/hazard_control_unit_pkg.sv
// Shared pipeline-control definitions: FSM states, register-address constants,
// the write-enable/flush control bundle and the load-use detect helper.
package hazard_control_unit_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] X0_ADDR = '0;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } hz_state_e;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic id_ex_write;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_bubble;
    } hz_ctrl_t;

    // Normal flow: every register loads, nothing is cleared.
    localparam hz_ctrl_t CTRL_RUN = '{pc_write: 1'b1, if_id_write: 1'b1, id_ex_write: 1'b1,
                                      if_id_flush: 1'b0, id_ex_flush: 1'b0, ex_mem_bubble: 1'b0};
    // Full freeze while the pipeline is held in reset.
    localparam hz_ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, if_id_write: 1'b0, id_ex_write: 1'b0,
                                         if_id_flush: 1'b1, id_ex_flush: 1'b1, ex_mem_bubble: 1'b1};
    // MDU occupying EX: hold the front end, feed bubbles into EX/MEM.
    localparam hz_ctrl_t CTRL_MDU_STALL = '{pc_write: 1'b0, if_id_write: 1'b0, id_ex_write: 1'b0,
                                            if_id_flush: 1'b0, id_ex_flush: 1'b0, ex_mem_bubble: 1'b1};
    // Load-use: hold IF and ID, insert one bubble into EX.
    localparam hz_ctrl_t CTRL_LOAD_USE = '{pc_write: 1'b0, if_id_write: 1'b0, id_ex_write: 1'b1,
                                           if_id_flush: 1'b0, id_ex_flush: 1'b1, ex_mem_bubble: 1'b0};
    // Taken branch: load the target, squash the two younger stages.
    localparam hz_ctrl_t CTRL_BRANCH = '{pc_write: 1'b1, if_id_write: 1'b1, id_ex_write: 1'b1,
                                         if_id_flush: 1'b1, id_ex_flush: 1'b1, ex_mem_bubble: 1'b0};

    // A load in EX whose non-x0 destination is read by the instruction in ID.
    function automatic logic is_load_use(
        input logic                  mem_read,
        input logic [REG_ADDR_W-1:0] rd,
        input logic [REG_ADDR_W-1:0] rs1,
        input logic [REG_ADDR_W-1:0] rs2,
        input logic                  uses_rs1,
        input logic                  uses_rs2
    );
        return mem_read && (rd != X0_ADDR) &&
               ((uses_rs1 && (rd == rs1)) || (uses_rs2 && (rd == rs2)));
    endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// ID/EX hazard observation signals and the resulting pipeline controls.
interface hazard_control_unit_if;

    logic [hazard_control_unit_pkg::REG_ADDR_W-1:0] IF_ID_REG_RS1_ADD;
    logic [hazard_control_unit_pkg::REG_ADDR_W-1:0] IF_ID_REG_RS2_ADD;
    logic                                           IF_ID_USES_RS1;
    logic                                           IF_ID_USES_RS2;
    logic [hazard_control_unit_pkg::REG_ADDR_W-1:0] ID_EX_REG_RD_ADD;
    logic                                           ID_EX_REG_MEM_CTRL_MemRead;
    logic                                           EX_MDU_START;
    logic                                           MDU_DONE;
    logic                                           EX_BRANCH_TAKEN;

    logic PC_Write;
    logic IF_ID_Write;
    logic ID_EX_Write;
    logic IF_ID_Flush;
    logic ID_EX_Flush;
    logic EX_MEM_Bubble;

    // Pipeline side: reports stage contents, consumes controls.
    modport master (
        output IF_ID_REG_RS1_ADD, IF_ID_REG_RS2_ADD, IF_ID_USES_RS1, IF_ID_USES_RS2,
               ID_EX_REG_RD_ADD, ID_EX_REG_MEM_CTRL_MemRead, EX_MDU_START, MDU_DONE,
               EX_BRANCH_TAKEN,
        input  PC_Write, IF_ID_Write, ID_EX_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Bubble
    );

    // Hazard unit side.
    modport slave (
        input  IF_ID_REG_RS1_ADD, IF_ID_REG_RS2_ADD, IF_ID_USES_RS1, IF_ID_USES_RS2,
               ID_EX_REG_RD_ADD, ID_EX_REG_MEM_CTRL_MemRead, EX_MDU_START, MDU_DONE,
               EX_BRANCH_TAKEN,
        output PC_Write, IF_ID_Write, ID_EX_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Bubble
    );

endinterface

// File: rtl/hazard_control_unit_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module hazard_control_unit_sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Synchronous clear, then saturating increment.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/hazard_control_unit.sv
// Stall/flush control for load-use, multi-cycle MDU and taken-branch hazards.
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MDU_TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    hazard_control_unit_if.slave      hz,
    output logic [CNT_W-1:0]          STALL_COUNT,
    output logic [CNT_W-1:0]          FLUSH_COUNT,
    output logic                      MDU_TIMEOUT_ERR
);

    localparam int unsigned WD_W = $clog2(MDU_TIMEOUT + 1);

    hz_state_e       state_q, state_d;
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            err_q, err_d;
    hz_ctrl_t        ctrl;
    logic            load_use;
    logic            stall_inc;
    logic            flush_inc;

    // Next-state, watchdog and zero-latency control decode.
    always_comb begin
        state_d   = state_q;
        wdog_d    = wdog_q;
        err_d     = err_q;
        ctrl      = CTRL_RUN;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        load_use  = is_load_use(hz.ID_EX_REG_MEM_CTRL_MemRead, hz.ID_EX_REG_RD_ADD,
                                hz.IF_ID_REG_RS1_ADD, hz.IF_ID_REG_RS2_ADD,
                                hz.IF_ID_USES_RS1, hz.IF_ID_USES_RS2);

        unique case (state_q)
            RUN: begin
                if (hz.EX_BRANCH_TAKEN) begin
                    ctrl      = CTRL_BRANCH;
                    flush_inc = 1'b1;
                end else if (hz.EX_MDU_START && !hz.MDU_DONE) begin
                    ctrl      = CTRL_MDU_STALL;
                    stall_inc = 1'b1;
                    state_d   = MDU_WAIT;
                    wdog_d    = WD_W'(1);
                end else if (hz.EX_MDU_START) begin
                    ctrl      = CTRL_RUN;
                end else if (load_use) begin
                    ctrl      = CTRL_LOAD_USE;
                    stall_inc = 1'b1;
                end
            end
            MDU_WAIT: begin
                if (hz.MDU_DONE) begin
                    state_d = RUN;
                    wdog_d  = '0;
                end else if (wdog_q == WD_W'(MDU_TIMEOUT)) begin
                    // Watchdog expiry: release the pipeline and flag the hang.
                    err_d   = 1'b1;
                    state_d = RUN;
                    wdog_d  = '0;
                end else begin
                    ctrl      = CTRL_MDU_STALL;
                    stall_inc = 1'b1;
                    wdog_d    = wdog_q + WD_W'(1);
                end
            end
            default: begin
                state_d = RUN;
                wdog_d  = '0;
            end
        endcase

        // Reset overrides everything with a full freeze.
        if (!rst_n) begin
            ctrl      = CTRL_FREEZE;
            stall_inc = 1'b0;
            flush_inc = 1'b0;
        end
    end

    // State, watchdog and sticky error registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            wdog_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wdog_q  <= wdog_d;
            err_q   <= err_d;
        end
    end

    hazard_control_unit_sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clr_n (rst_n),
        .inc   (stall_inc),
        .count (STALL_COUNT)
    );

    hazard_control_unit_sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clr_n (rst_n),
        .inc   (flush_inc),
        .count (FLUSH_COUNT)
    );

    assign hz.PC_Write      = ctrl.pc_write;
    assign hz.IF_ID_Write   = ctrl.if_id_write;
    assign hz.ID_EX_Write   = ctrl.id_ex_write;
    assign hz.IF_ID_Flush   = ctrl.if_id_flush;
    assign hz.ID_EX_Flush   = ctrl.id_ex_flush;
    assign hz.EX_MEM_Bubble = ctrl.ex_mem_bubble;
    assign MDU_TIMEOUT_ERR  = err_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit (CNT_W=4, MDU_TIMEOUT=8).
module tb_hazard_control_unit;

    localparam int unsigned CNT_W = 4;

    // Expected control vectors: {PC_Write, IF_ID_Write, ID_EX_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Bubble}
    localparam logic [5:0] E_RUN    = 6'b111000;
    localparam logic [5:0] E_FREEZE = 6'b000111;
    localparam logic [5:0] E_MDU    = 6'b000001;
    localparam logic [5:0] E_LU     = 6'b001010;
    localparam logic [5:0] E_BR     = 6'b111110;

    logic             clk;
    logic             rst_n;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;
    logic             mdu_err;
    int               checks;
    int               failures;

    hazard_control_unit_if hz_if ();

    hazard_control_unit #(.CNT_W(CNT_W), .MDU_TIMEOUT(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .hz              (hz_if),
        .STALL_COUNT     (stall_count),
        .FLUSH_COUNT     (flush_count),
        .MDU_TIMEOUT_ERR (mdu_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] ctrl_obs();
        return {hz_if.PC_Write, hz_if.IF_ID_Write, hz_if.ID_EX_Write,
                hz_if.IF_ID_Flush, hz_if.ID_EX_Flush, hz_if.EX_MEM_Bubble};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        hz_if.IF_ID_REG_RS1_ADD          = 5'd0;
        hz_if.IF_ID_REG_RS2_ADD          = 5'd0;
        hz_if.IF_ID_USES_RS1             = 1'b0;
        hz_if.IF_ID_USES_RS2             = 1'b0;
        hz_if.ID_EX_REG_RD_ADD           = 5'd0;
        hz_if.ID_EX_REG_MEM_CTRL_MemRead = 1'b0;
        hz_if.EX_MDU_START               = 1'b0;
        hz_if.MDU_DONE                   = 1'b0;
        hz_if.EX_BRANCH_TAKEN            = 1'b0;
    endtask

    task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic use1);
        hz_if.ID_EX_REG_MEM_CTRL_MemRead = 1'b1;
        hz_if.ID_EX_REG_RD_ADD           = rd;
        hz_if.IF_ID_REG_RS1_ADD          = rs1;
        hz_if.IF_ID_USES_RS1             = use1;
    endtask

    task automatic apply_reset();
        set_idle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        set_idle();
        rst_n = 1'b0;
        #1;
        checks++; if (ctrl_obs() !== E_FREEZE) begin failures++; $display("FAIL reset_freeze got=%b exp=%b", ctrl_obs(), E_FREEZE); end
        tick();
        tick();
        checks++; if (stall_count !== 4'd0 || flush_count !== 4'd0 || mdu_err !== 1'b0) begin failures++; $display("FAIL reset_regs stall=%0d flush=%0d err=%b exp=0/0/0", stall_count, flush_count, mdu_err); end
        rst_n = 1'b1;
        #1;
        checks++; if (ctrl_obs() !== E_RUN) begin failures++; $display("FAIL reset_release got=%b exp=%b", ctrl_obs(), E_RUN); end
    endtask

    task automatic test_load_use();
        apply_reset();
        set_load_use(5'd5, 5'd5, 1'b1);
        #1;
        checks++; if (ctrl_obs() !== E_LU) begin failures++; $display("FAIL lu_ctrl got=%b exp=%b", ctrl_obs(), E_LU); end
        tick();
        hz_if.ID_EX_REG_MEM_CTRL_MemRead = 1'b0;
        #1;
        checks++; if (ctrl_obs() !== E_RUN) begin failures++; $display("FAIL lu_after got=%b exp=%b", ctrl_obs(), E_RUN); end
        checks++; if (stall_count !== 4'd1) begin failures++; $display("FAIL lu_count got=%0d exp=1", stall_count); end
        // rs2 path
        set_idle();
        hz_if.ID_EX_REG_MEM_CTRL_MemRead = 1'b1;
        hz_if.ID_EX_REG_RD_ADD           = 5'd7;
        hz_if.IF_ID_REG_RS2_ADD          = 5'd7;
        hz_if.IF_ID_USES_RS2             = 1'b1;
        #1;
        checks++; if (ctrl_obs() !== E_LU) begin failures++; $display("FAIL lu_rs2 got=%b exp=%b", ctrl_obs(), E_LU); end
        tick();
        set_idle();
        #1;
        checks++; if (stall_count !== 4'd2) begin failures++; $display("FAIL lu_rs2_count got=%0d exp=2", stall_count); end
    endtask

    task automatic test_no_stall();
        apply_reset();
        set_load_use(5'd0, 5'd0, 1'b1);
        #1;
        checks++; if (ctrl_obs() !== E_RUN) begin failures++; $display("FAIL ns_rd0 got=%b exp=%b", ctrl_obs(), E_RUN); end
        tick();
        set_load_use(5'd5, 5'd5, 1'b0);
        #1;
        checks++; if (ctrl_obs() !== E_RUN) begin failures++; $display("FAIL ns_nouse got=%b exp=%b", ctrl_obs(), E_RUN); end
        tick();
        set_load_use(5'd5, 5'd6, 1'b1);
        #1;
        checks++; if (ctrl_obs() !== E_RUN) begin failures++; $display("FAIL ns_diff got=%b exp=%b", ctrl_obs(), E_RUN); end
        tick();
        set_idle();
        #1;
        checks++; if (stall_count !== 4'd0) begin failures++; $display("FAIL ns_count got=%0d exp=0", stall_count); end
    endtask

    task automatic test_mdu();
        apply_reset();
        hz_if.EX_MDU_START = 1'b1;
        #1;
        checks++; if (ctrl_obs() !== E_MDU) begin failures++; $display("FAIL mdu_start got=%b exp=%b", ctrl_obs(), E_MDU); end
        tick();
        hz_if.EX_MDU_START = 1'b0;
        for (int i = 1; i < 4; i++) begin
            // Branch and load-use in MDU_WAIT must be ignored
            hz_if.EX_BRANCH_TAKEN = (i == 2);
            if (i == 2) set_load_use(5'd3, 5'd3, 1'b1);
            #1;
            checks++; if (ctrl_obs() !== E_MDU) begin failures++; $display("FAIL mdu_wait%0d got=%b exp=%b", i, ctrl_obs(), E_MDU); end
            tick();
            set_idle();
        end
        hz_if.MDU_DONE = 1'b1;
        #1;
        checks++; if (ctrl_obs() !== E_RUN) begin failures++; $display("FAIL mdu_done got=%b exp=%b", ctrl_obs(), E_RUN); end
        tick();
        set_idle();
        #1;
        checks++; if (stall_count !== 4'd4 || flush_count !== 4'd0) begin failures++; $display("FAIL mdu_count stall=%0d flush=%0d exp=4/0", stall_count, flush_count); end
        checks++; if (ctrl_obs() !== E_RUN) begin failures++; $display("FAIL mdu_run got=%b exp=%b", ctrl_obs(), E_RUN); end
        // single-cycle op
        hz_if.EX_MDU_START = 1'b1;
        hz_if.MDU_DONE     = 1'b1;
        #1;
        checks++; if (ctrl_obs() !== E_RUN) begin failures++; $display("FAIL mdu_single got=%b exp=%b", ctrl_obs(), E_RUN); end
        tick();
        set_idle();
        #1;
        checks++; if (ctrl_obs() !== E_RUN || stall_count !== 4'd4) begin failures++; $display("FAIL mdu_single_after ctrl=%b stall=%0d exp=%b/4", ctrl_obs(), stall_count, E_RUN); end
    endtask

    task automatic test_branch();
        apply_reset();
        set_load_use(5'd5, 5'd5, 1'b1);
        hz_if.EX_BRANCH_TAKEN = 1'b1;
        hz_if.EX_MDU_START    = 1'b1;
        #1;
        checks++; if (ctrl_obs() !== E_BR) begin failures++; $display("FAIL br_ctrl got=%b exp=%b", ctrl_obs(), E_BR); end
        tick();
        set_idle();
        #1;
        checks++; if (flush_count !== 4'd1 || stall_count !== 4'd0) begin failures++; $display("FAIL br_count flush=%0d stall=%0d exp=1/0", flush_count, stall_count); end
        checks++; if (ctrl_obs() !== E_RUN) begin failures++; $display("FAIL br_after got=%b exp=%b", ctrl_obs(), E_RUN); end
    endtask

    task automatic test_timeout();
        apply_reset();
        hz_if.EX_MDU_START = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++; if (ctrl_obs() !== E_MDU || mdu_err !== 1'b0) begin failures++; $display("FAIL to_freeze%0d ctrl=%b err=%b exp=%b/0", i, ctrl_obs(), mdu_err, E_MDU); end
            tick();
            hz_if.EX_MDU_START = 1'b0;
        end
        #1;
        checks++; if (ctrl_obs() !== E_RUN) begin failures++; $display("FAIL to_release got=%b exp=%b", ctrl_obs(), E_RUN); end
        tick();
        checks++; if (mdu_err !== 1'b1 || stall_count !== 4'd8) begin failures++; $display("FAIL to_err err=%b stall=%0d exp=1/8", mdu_err, stall_count); end
        set_load_use(5'd9, 5'd9, 1'b1);
        #1;
        checks++; if (ctrl_obs() !== E_LU) begin failures++; $display("FAIL to_run got=%b exp=%b", ctrl_obs(), E_LU); end
        tick();
        set_idle();
        tick();
        tick();
        checks++; if (mdu_err !== 1'b1) begin failures++; $display("FAIL to_sticky got=%b exp=1", mdu_err); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        checks++; if (mdu_err !== 1'b0) begin failures++; $display("FAIL to_clear got=%b exp=0", mdu_err); end
    endtask

    task automatic test_saturation();
        apply_reset();
        set_load_use(5'd4, 5'd4, 1'b1);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 13) begin
                checks++; if (stall_count !== 4'd14) begin failures++; $display("FAIL sat_mid got=%0d exp=14", stall_count); end
            end
        end
        set_idle();
        #1;
        checks++; if (stall_count !== 4'd15) begin failures++; $display("FAIL sat_hold got=%0d exp=15", stall_count); end
    endtask

    task automatic test_reset_mid_wait();
        apply_reset();
        hz_if.EX_MDU_START = 1'b1;
        tick();
        hz_if.EX_MDU_START = 1'b0;
        tick();
        checks++; if (ctrl_obs() !== E_MDU || stall_count !== 4'd2) begin failures++; $display("FAIL rw_wait ctrl=%b stall=%0d exp=%b/2", ctrl_obs(), stall_count, E_MDU); end
        rst_n = 1'b0;
        #1;
        checks++; if (ctrl_obs() !== E_FREEZE) begin failures++; $display("FAIL rw_freeze got=%b exp=%b", ctrl_obs(), E_FREEZE); end
        tick();
        checks++; if (ctrl_obs() !== E_FREEZE || stall_count !== 4'd0) begin failures++; $display("FAIL rw_low ctrl=%b stall=%0d exp=%b/0", ctrl_obs(), stall_count, E_FREEZE); end
        rst_n = 1'b1;
        #1;
        checks++; if (ctrl_obs() !== E_RUN) begin failures++; $display("FAIL rw_run got=%b exp=%b", ctrl_obs(), E_RUN); end
        tick();
        checks++; if (stall_count !== 4'd0 || ctrl_obs() !== E_RUN) begin failures++; $display("FAIL rw_after stall=%0d ctrl=%b exp=0/%b", stall_count, ctrl_obs(), E_RUN); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        set_idle();
        test_reset();
        test_load_use();
        test_no_stall();
        test_mdu();
        test_branch();
        test_timeout();
        test_saturation();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Stall/flush counterpart to the pipeline's operand forwarding logic.
- Resolves the hazards that bypassing cannot cover:
  - load-use dependencies, by stalling one cycle and inserting a bubble;
  - multi-cycle MUL/DIV occupancy of EX, by freezing the front end until done;
  - taken branches resolved in EX, by flushing the two younger stages.
- Sits beside the ID and EX stages and drives the PC and pipeline-register write-enable and flush controls.
- Keeps saturating stall and flush event counters and an MDU watchdog.

Parameters:
- CNT_W, 32, width of STALL_COUNT and FLUSH_COUNT.
- MDU_TIMEOUT, 64, maximum number of cycles in MDU_WAIT before the watchdog fires.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  synchronous, active-low reset
- IF_ID_REG_RS1_ADD  input  5  rs1 address of the instruction in ID
- IF_ID_REG_RS2_ADD  input  5  rs2 address of the instruction in ID
- IF_ID_USES_RS1  input  1  ID instruction actually reads rs1
- IF_ID_USES_RS2  input  1  ID instruction actually reads rs2
- ID_EX_REG_RD_ADD  input  5  rd address of the instruction in EX
- ID_EX_REG_MEM_CTRL_MemRead  input  1  instruction in EX is a load
- EX_MDU_START  input  1  multi-cycle MUL/DIV occupies EX this cycle (first cycle)
- MDU_DONE  input  1  MDU result valid this cycle
- EX_BRANCH_TAKEN  input  1  branch/jump in EX redirects the PC
- PC_Write  output  1  PC register load enable
- IF_ID_Write  output  1  IF/ID register load enable
- ID_EX_Write  output  1  ID/EX register load enable
- IF_ID_Flush  output  1  clear IF/ID to a NOP
- ID_EX_Flush  output  1  zero the ID/EX control fields (bubble)
- EX_MEM_Bubble  output  1  zero the EX/MEM control fields
- STALL_COUNT  output  CNT_W  total stall cycles, saturating
- FLUSH_COUNT  output  CNT_W  total taken-branch flush events, saturating
- MDU_TIMEOUT_ERR  output  1  sticky watchdog error flag

Behaviour:
- **Reset:** rst_n low at a clk edge sets state=RUN, both counters=0, watchdog=0, MDU_TIMEOUT_ERR=0.
  - While rst_n is low, the control outputs are forced to freeze: PC_Write=IF_ID_Write=ID_EX_Write=0, IF_ID_Flush=ID_EX_Flush=EX_MEM_Bubble=1.
  - Reset asserted mid-stall abandons MDU_WAIT immediately.
- **Control outputs:** combinational from state and inputs, zero latency. Counters and state are registered and update on the next edge.
- **Default in RUN:** all Write=1, all Flush/Bubble=0.
- **load_use** = ID_EX_REG_MEM_CTRL_MemRead && ID_EX_REG_RD_ADD!=0 && ((IF_ID_USES_RS1 && RD==RS1) || (IF_ID_USES_RS2 && RD==RS2)).
- **RUN priority, highest first:**
  1. EX_BRANCH_TAKEN:
     - IF_ID_Flush=1 and ID_EX_Flush=1; PC_Write=1 (target loads).
     - FLUSH_COUNT+1.
     - load_use and EX_MDU_START are ignored this cycle.
  2. EX_MDU_START && !MDU_DONE:
     - PC_Write=IF_ID_Write=ID_EX_Write=0, EX_MEM_Bubble=1.
     - STALL_COUNT+1; next state=MDU_WAIT; watchdog=1.
  3. EX_MDU_START && MDU_DONE (single-cycle op): no stall, stay in RUN.
  4. load_use:
     - PC_Write=IF_ID_Write=0, ID_EX_Flush=1.
     - STALL_COUNT+1.
     - Exactly one cycle: the next cycle EX holds a bubble, so load_use cannot re-fire for the same pair.
- **MDU_WAIT:**
  - Without MDU_DONE: same freeze outputs as RUN item 2; STALL_COUNT+1; watchdog+1.
  - MDU_DONE: release the same cycle (RUN defaults, EX_MEM_Bubble=0 so the result enters EX/MEM); next state=RUN. load_use and branch inputs are ignored in this state.
  - Watchdog reaches MDU_TIMEOUT without MDU_DONE: set MDU_TIMEOUT_ERR (sticky until reset), outputs released that cycle, next state=RUN.
- **Counters:** saturate at all-ones and never wrap. At most one increment per cycle each.
- **Watchdog width:** clog2(MDU_TIMEOUT+1).

Decomposition:
- Shared pipeline package holds:
  - state enum (RUN, MDU_WAIT);
  - REG_ADDR_W=5 and the X0 address constant;
  - the freeze/release control bundle constants reused by other pipeline control blocks.
- One natural sub-module: sat_counter (parameter width, inc, sync active-low clear), instanced twice.

Test Plan:
- Load x5 in EX (MemRead=1, RD=5), ID reads RS1=5 with USES_RS1=1
  - -> one cycle of PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1; STALL_COUNT 0->1; defaults the following cycle.
- Same as the load-use case but RD=0, or USES_RS1=0 -> no stall, counter stays 0.
- EX_MDU_START pulse, then MDU_DONE 4 cycles later
  - -> 4 freeze cycles with EX_MEM_Bubble=1; release on the DONE cycle; STALL_COUNT=4.
- EX_BRANCH_TAKEN together with an active load_use
  - -> IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1, no stall; FLUSH_COUNT=1, STALL_COUNT=0.
- MDU_TIMEOUT=8, EX_MDU_START with MDU_DONE never asserted
  - -> MDU_TIMEOUT_ERR rises after 8 cycles, state returns to RUN, and ERR holds until rst_n=0.
- Counter saturation and reset
  - Preload with CNT_W=4: 20 load-use stalls -> STALL_COUNT holds 15.
  - rst_n=0 during MDU_WAIT -> outputs forced to freeze while low, state=RUN and counters=0 after release.
